mvau_act_thresh: RTL and testbench



---
 rtl/mvau_defn.sv | 21 ++
 rtl/mvau_thresh_cmp.sv | 29 ++
 rtl/mvau_act_thresh.sv | 103 ++++++++++
 tb/tb_mvau_act_thresh.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mvau_defn.sv
// -----------------------------------------------------------------------------
// mvau_defn -- shared definitions for the MVAU multi-threshold activation stage.
//   PE   : lanes per beat (output channels processed in parallel)
//   NF   : neuron folds; channel of lane p at fold f is f*PE+p
//   TA   : signed accumulator / threshold width
//   OB   : output bits per lane
//   NT   : thresholds per channel (2**OB - 1)
//   NF_T : width of the fold counter
// -----------------------------------------------------------------------------
package mvau_defn;

  localparam int PE   = 2;
  localparam int NF   = 4;
  localparam int TA   = 16;
  localparam int OB   = 2;
  localparam int NT   = (1 << OB) - 1;
  localparam int NF_T = $clog2(NF);

  typedef logic signed [TA-1:0] acc_t;

endpackage

// File: rtl/mvau_thresh_cmp.sv
// -----------------------------------------------------------------------------
// mvau_thresh_cmp -- combinational compare-and-count for one lane.
//   acc : signed accumulator value
//   thr : NT thresholds, threshold t at bits [t*TA +: TA], signed
//   cnt : number of thresholds with acc >= thr[t] (0..NT, fits OB bits)
// The result is a plain population count, so a non-ascending table still
// yields a well-defined value.
// -----------------------------------------------------------------------------
module mvau_thresh_cmp
  import mvau_defn::*;
(
  input  acc_t             acc,
  input  logic [NT*TA-1:0] thr,
  output logic [OB-1:0]    cnt
);

  always_comb begin
    // NOTE: combinational logic uses blocking '='; the default assignment
    // first guarantees every path drives cnt, so no latch is inferred.
    cnt = '0;
    for (int t = 0; t < NT; t++) begin
      // Both operands are signed TA-bit values: a true signed compare.
      if (acc >= acc_t'(thr[t*TA +: TA])) begin
        cnt = cnt + OB'(1);
      end
    end
  end

endmodule

// File: rtl/mvau_act_thresh.sv
// -----------------------------------------------------------------------------
// mvau_act_thresh -- multi-threshold activation stage behind the MVAU.
//   clk     : main clock
//   rst     : asynchronous reset, active-high
//   thres   : static threshold table, channel c / threshold t at
//             bits [(c*NT+t)*TA +: TA], ascending per channel
//   in_v    : input beat valid
//   in_r    : input ready
//   in_acc  : PE signed accumulators, lane p at bits [p*TA +: TA]
//   out_v   : output beat valid
//   out_r   : downstream ready
//   out_act : PE unsigned activations, lane p at bits [p*OB +: OB]
//
// Two-stage pipeline. Stage 1 captures the accumulators together with the
// thresholds of the current fold, so the fold counter can run ahead freely.
// Stage 2 holds the counted activations. Full backpressure: in_r depends on
// pipeline occupancy and out_r only, never on in_v.
// -----------------------------------------------------------------------------
module mvau_act_thresh
  import mvau_defn::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PE*NF*NT*TA-1:0] thres,
  input  logic                   in_v,
  output logic                   in_r,
  input  logic [PE*TA-1:0]       in_acc,
  output logic                   out_v,
  input  logic                   out_r,
  output logic [PE*OB-1:0]       out_act
);

  // Threshold bits belonging to one lane.
  localparam int LW = NT * TA;

  logic [NF_T-1:0]    nf_cnt;
  logic               s1_v;
  logic               s2_v;
  logic [PE*TA-1:0]   s1_acc;
  logic [PE*LW-1:0]   s1_thr;
  logic [PE*LW-1:0]   thr_sel;
  logic [PE*OB-1:0]   act_d;
  logic               adv;
  logic               xfer;

  assign adv   = !s2_v || out_r;
  assign in_r  = !s1_v || adv;
  assign xfer  = in_v && in_r;
  assign out_v = s2_v;

  // The PE channels of one fold are contiguous in the table.
  assign thr_sel = thres[int'(nf_cnt)*PE*LW +: PE*LW];

  // Control state: fold counter and stage valids.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking '<=' so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      nf_cnt <= '0;
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
    end else begin
      if (xfer) begin
        nf_cnt <= (nf_cnt == NF_T'(NF - 1)) ? '0 : nf_cnt + 1'b1;
      end
      // Stage 1 refills (or empties) whenever it is free or moving on.
      if (in_r) begin
        s1_v <= in_v;
      end
      if (adv) begin
        s2_v <= s1_v;
      end
    end
  end

  // NOTE: stage-1 datapath registers carry no reset; their contents are
  // only observed when s1_v is set, which is reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_acc <= in_acc;
      s1_thr <= thr_sel;
    end
  end

  for (genvar p = 0; p < PE; p++) begin : g_lane
    mvau_thresh_cmp u_cmp (
      .acc (acc_t'(s1_acc[p*TA +: TA])),
      .thr (s1_thr[p*LW +: LW]),
      .cnt (act_d[p*OB +: OB])
    );
  end

  // Output register; held while stalled so out_act is stable under
  // out_v && !out_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_act <= '0;
    end else if (adv && s1_v) begin
      out_act <= act_d;
    end
  end

endmodule

// File: tb/tb_mvau_act_thresh.sv
// -----------------------------------------------------------------------------
// tb_mvau_act_thresh -- directed self-checking bench for mvau_act_thresh.
// Inputs are driven on the falling edge; outputs are sampled shortly after
// the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_mvau_act_thresh;
  import mvau_defn::*;

  logic                   clk;
  logic                   rst;
  logic [PE*NF*NT*TA-1:0] thres;
  logic                   in_v;
  logic                   in_r;
  logic [PE*TA-1:0]       in_acc;
  logic                   out_v;
  logic                   out_r;
  logic [PE*OB-1:0]       out_act;

  int n_pass  = 0;
  int n_total = 0;

  int thr_tab [PE*NF][NT];

  // Scoreboard state for the streaming tests.
  logic [PE*OB-1:0] exp_q [$];
  int m_fold   = 0;
  int inflight = 0;

  mvau_act_thresh dut (
    .clk     (clk),
    .rst     (rst),
    .thres   (thres),
    .in_v    (in_v),
    .in_r    (in_r),
    .in_acc  (in_acc),
    .out_v   (out_v),
    .out_r   (out_r),
    .out_act (out_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply_thr();
    for (int c = 0; c < PE*NF; c++)
      for (int t = 0; t < NT; t++)
        thres[(c*NT+t)*TA +: TA] = TA'(thr_tab[c][t]);
  endtask

  task automatic set_uniform(input int a, input int b, input int c);
    for (int ch = 0; ch < PE*NF; ch++) begin
      thr_tab[ch][0] = a;
      thr_tab[ch][1] = b;
      thr_tab[ch][2] = c;
    end
    apply_thr();
  endtask

  task automatic set_fold_table();
    for (int ch = 0; ch < PE*NF; ch++) begin
      thr_tab[ch][0] = ch;
      thr_tab[ch][1] = 10 + ch;
      thr_tab[ch][2] = 20 + ch;
    end
    apply_thr();
  endtask

  // Reference: population count of thresholds reached, per lane.
  function automatic logic [PE*OB-1:0] ref_act(input logic [PE*TA-1:0] w, input int fold);
    logic [PE*OB-1:0] r;
    r = '0;
    for (int p = 0; p < PE; p++) begin
      logic signed [TA-1:0] a;
      int n;
      a = w[p*TA +: TA];
      n = 0;
      for (int t = 0; t < NT; t++)
        if (int'(a) >= thr_tab[fold*PE+p][t]) n++;
      r[p*OB +: OB] = OB'(n);
    end
    return r;
  endfunction

  task automatic reset_model();
    exp_q.delete();
    m_fold   = 0;
    inflight = 0;
  endtask

  // Stream n beats of random data, with out_r low for stall_len cycles
  // starting at cycle stall_at. Every handshake is scoreboarded.
  task automatic run_stream(input int n, input int stall_at, input int stall_len, input bit chk_ov);
    int sent   = 0;
    int popped = 0;
    int cyc    = 0;
    bit held_v = 0;
    logic [PE*OB-1:0] held = '0;
    logic signed [TA-1:0] a0, a1;
    while (popped < n && cyc < n + 40) begin
      @(negedge clk);
      out_r = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_v  = (sent < n);
      a0 = TA'(int'($urandom_range(60)) - 20);
      a1 = TA'(int'($urandom_range(60)) - 20);
      in_acc = {a1, a0};
      #1;
      check("in_r_vs_occupancy", in_r, (inflight < 2) || out_r);
      if (chk_ov && cyc >= 2 && cyc < n) check("stream_out_v", out_v, 1);
      if (out_v && !out_r) begin
        if (held_v) check("stall_hold", out_act, held);
        held   = out_act;
        held_v = 1;
      end else begin
        held_v = 0;
      end
      if (out_v && out_r) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $error("FAIL extra_output: observed %0h expected none", out_act);
        end else begin
          check("stream_data", out_act, exp_q.pop_front());
        end
        popped++;
        inflight--;
      end
      if (in_v && in_r) begin
        exp_q.push_back(ref_act(in_acc, m_fold));
        m_fold = (m_fold + 1) % NF;
        inflight++;
        sent++;
      end
      cyc++;
    end
    in_v  = 1'b0;
    out_r = 1'b1;
    check("stream_count", popped, n);
    check("stream_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst    = 1'b1;
    in_v   = 1'b0;
    out_r  = 1'b1;
    in_acc = '0;
    thres  = '0;
    set_uniform(-5, 0, 7);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_r", in_r, 1);
    check("rst_out_v", out_v, 0);
    check("rst_out_act", out_act, 0);
    rst = 1'b0;

    // Basic: lanes {-6, 7} -> {0, 3}, two cycles after transfer.
    @(negedge clk);
    in_v   = 1'b1;
    in_acc = {16'd7, 16'hfffa};
    @(negedge clk);
    in_v = 1'b0;
    check("basic_lat1_out_v", out_v, 0);
    @(negedge clk);
    check("basic_out_v", out_v, 1);
    check("basic_act", out_act, 4'b1100);

    // Equality and extremes: {0, -32768} -> {2, 0}; {32767, -5} -> {3, 1}.
    in_v   = 1'b1;
    in_acc = {16'h8000, 16'h0000};
    @(negedge clk);
    check("eq_gap_out_v", out_v, 0);
    in_acc = {16'hfffb, 16'h7fff};
    @(negedge clk);
    in_v = 1'b0;
    check("eq_a_act", out_act, 4'b0010);
    @(negedge clk);
    check("eq_b_out_v", out_v, 1);
    check("eq_b_act", out_act, 4'b0111);
    @(negedge clk);
    check("eq_drained", out_v, 0);

    // Fold tracking from a clean counter: channel c = {c, 10+c, 20+c}, acc = 10.
    // Channel 0 reaches two thresholds, every other channel reaches one.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    reset_model();
    set_fold_table();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("fold_out_v_%0d", i-2), out_v, 1);
        check($sformatf("fold_act_%0d", i-2), out_act, ((i-2) % NF == 0) ? 4'b0110 : 4'b0101);
      end
      in_v   = (i < 8);
      in_acc = {16'd10, 16'd10};
    end
    in_v = 1'b0;
    @(negedge clk);

    // Backpressure: 6 beats, out_r low for 3 cycles mid-stream.
    run_stream(6, 3, 3, 1'b0);

    // Continuous streaming: 100 beats back-to-back.
    run_stream(100, 1000, 0, 1'b1);

    // One more beat so the fold counter is off zero before the reset test.
    run_stream(1, 1000, 0, 1'b0);

    // Async reset with two beats held in the pipe.
    @(negedge clk);
    in_v   = 1'b1;
    in_acc = {16'd10, 16'd10};
    out_r  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_v = 1'b0;
    check("pre_rst_out_v", out_v, 1);
    check("pre_rst_in_r", in_r, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_v", out_v, 0);
    check("mid_rst_in_r", in_r, 1);
    check("mid_rst_out_act", out_act, 0);
    #1 rst = 1'b0;
    reset_model();
    out_r = 1'b1;
    @(negedge clk);
    in_v   = 1'b1;
    in_acc = {16'd10, 16'd10};
    @(negedge clk);
    in_v = 1'b0;
    check("post_rst_lat1", out_v, 0);
    @(negedge clk);
    check("post_rst_out_v", out_v, 1);
    check("post_rst_fold0", out_act, 4'b0110);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
